// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared encodings for the matrix-multiply memory agent
package matmul_pkg;

    localparam logic [1:0] SEL_J = 2'd0;
    localparam logic [1:0] SEL_K = 2'd1;
    localparam logic [1:0] SEL_L = 2'd2;
    localparam logic [1:0] SEL_M = 2'd3;

    // op_we is {weA,weB,...,weH}, so weA sits in the MSB
    localparam int WE_A = 7;
    localparam int WE_B = 6;
    localparam int WE_C = 5;
    localparam int WE_D = 4;
    localparam int WE_E = 3;
    localparam int WE_F = 2;
    localparam int WE_G = 1;
    localparam int WE_H = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tile_addr_calc.sv
// rtl/tile_addr_calc.sv - row-major element address: base + row*DIM + col
module tile_addr_calc #(
    parameter int DIM    = 4,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] addr
);

    // Wraps naturally modulo 2^ADDR_W
    assign addr = base + row * ADDR_W'(DIM) + col;

endmodule

// File: rtl/matmul_mem_agent.sv
// rtl/matmul_mem_agent.sv - turns matmul controller strobes into operand/result memory addresses
module matmul_mem_agent
    import matmul_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int ADDR_W = 10,
    parameter int X_BASE = 0,
    parameter int Y_BASE = 16,
    parameter int Z_BASE = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        op_we,
    input  logic              data_we,
    input  logic [1:0]        jklm_select,
    input  logic              next_row,
    input  logic              column,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              mat_done,
    output logic              proto_err
);

    localparam int T     = DIM / 2;
    localparam int PTR_W = (T > 1) ? $clog2(T) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(T - 1);

    state_t           state;
    state_t           state_n;
    logic [PTR_W-1:0] r;
    logic [PTR_W-1:0] c;
    logic [PTR_W-1:0] k;

    logic              multi_op;
    logic              err;
    logic              any_strobe;
    logic              last_tile;
    logic              rd_fire;
    logic              wr_fire;
    logic              x_side;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W-1:0] rd_col;
    logic [ADDR_W-1:0] wr_row;
    logic [ADDR_W-1:0] wr_col;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [ADDR_W-1:0] wr_addr_c;

    // Strobe classification, protocol checking and next-state decode
    always_comb begin
        multi_op   = (op_we & (op_we - 8'd1)) != 8'd0;
        err        = multi_op || ((op_we != 8'd0) && data_we);
        any_strobe = (op_we != 8'd0) || data_we || next_row || column;
        last_tile  = (r == PTR_LAST) && (c == PTR_LAST);
        rd_fire    = !err && (op_we != 8'd0);
        wr_fire    = !err && data_we;
        state_n    = state;
        if (column && last_tile) begin
            state_n = DONE;
        end else if (any_strobe) begin
            state_n = RUN;
        end
    end

    // Operand element selection: A..D walk the X tile at (r,k), E..H the Y tile at (k,c)
    always_comb begin
        x_side = op_we[WE_A] | op_we[WE_B] | op_we[WE_C] | op_we[WE_D];
        if (x_side) begin
            rd_base = ADDR_W'(X_BASE);
            rd_row  = (ADDR_W'(r) << 1) + ADDR_W'(op_we[WE_C] | op_we[WE_D]);
            rd_col  = (ADDR_W'(k) << 1) + ADDR_W'(op_we[WE_B] | op_we[WE_D]);
        end else begin
            rd_base = ADDR_W'(Y_BASE);
            rd_row  = (ADDR_W'(k) << 1) + ADDR_W'(op_we[WE_G] | op_we[WE_H]);
            rd_col  = (ADDR_W'(c) << 1) + ADDR_W'(op_we[WE_F] | op_we[WE_H]);
        end
        // J/K share the top row of the Z tile, K/M the right column
        wr_row = (ADDR_W'(r) << 1) + ADDR_W'(jklm_select[1]);
        wr_col = (ADDR_W'(c) << 1) + ADDR_W'(jklm_select[0]);
    end

    tile_addr_calc #(.DIM(DIM), .ADDR_W(ADDR_W)) u_rd_calc (
        .base (rd_base),
        .row  (rd_row),
        .col  (rd_col),
        .addr (rd_addr_c)
    );

    tile_addr_calc #(.DIM(DIM), .ADDR_W(ADDR_W)) u_wr_calc (
        .base (ADDR_W'(Z_BASE)),
        .row  (wr_row),
        .col  (wr_col),
        .addr (wr_addr_c)
    );

    // Registered outputs, tile pointers and pass FSM
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            mat_done  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rd_en <= rd_fire;
            wr_en <= wr_fire;
            if (rd_fire) begin
                rd_addr <= rd_addr_c;
            end
            if (wr_fire) begin
                wr_addr <= wr_addr_c;
            end
            if (err) begin
                proto_err <= 1'b1;
            end

            // column outranks next_row; both only move pointers after this cycle's addresses
            if (column) begin
                k <= '0;
                if (c == PTR_LAST) begin
                    c <= '0;
                    r <= (r == PTR_LAST) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end else if (next_row) begin
                k <= (k == PTR_LAST) ? '0 : k + 1'b1;
            end

            state    <= state_n;
            mat_done <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_matmul_mem_agent.sv
// tb/tb_matmul_mem_agent.sv - self-checking bench for matmul_mem_agent
module tb_matmul_mem_agent;

    localparam int DIM    = 4;
    localparam int ADDR_W = 10;
    localparam int X_BASE = 0;
    localparam int Y_BASE = 16;
    localparam int Z_BASE = 32;
    localparam int T      = DIM / 2;
    localparam int AMOD   = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [7:0]        op_we = '0;
    logic              data_we = 1'b0;
    logic [1:0]        jklm_select = '0;
    logic              next_row = 1'b0;
    logic              column = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              mat_done;
    logic              proto_err;

    int errors = 0;
    int checks = 0;

    // Reference model: tile coordinates as plain integers
    int mr, mc, mk;
    bit mdone, mproto, mrd_en, mwr_en;
    int mrd_addr, mwr_addr;

    matmul_mem_agent #(
        .DIM(DIM), .ADDR_W(ADDR_W), .X_BASE(X_BASE), .Y_BASE(Y_BASE), .Z_BASE(Z_BASE)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .op_we       (op_we),
        .data_we     (data_we),
        .jklm_select (jklm_select),
        .next_row    (next_row),
        .column      (column),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .mat_done    (mat_done),
        .proto_err   (proto_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int elem(int base, int row, int col);
        return (base + row * DIM + col) % AMOD;
    endfunction

    // Operand i: 0..3 = A..D in X tile (r,k); 4..7 = E..H in Y tile (k,c)
    function automatic int operand_addr(int i);
        if (i < 4) return elem(X_BASE, 2 * mr + i / 2, 2 * mk + i % 2);
        return elem(Y_BASE, 2 * mk + (i - 4) / 2, 2 * mc + (i - 4) % 2);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rd_en"},     32'(rd_en),     32'(mrd_en));
        check({tag, ".rd_addr"},   32'(rd_addr),   32'(mrd_addr));
        check({tag, ".wr_en"},     32'(wr_en),     32'(mwr_en));
        check({tag, ".wr_addr"},   32'(wr_addr),   32'(mwr_addr));
        check({tag, ".mat_done"},  32'(mat_done),  32'(mdone));
        check({tag, ".proto_err"}, 32'(proto_err), 32'(mproto));
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        op_we = '0; data_we = 1'b0; jklm_select = '0; next_row = 1'b0; column = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        mr = 0; mc = 0; mk = 0;
        mdone = 0; mproto = 0; mrd_en = 0; mwr_en = 0; mrd_addr = 0; mwr_addr = 0;
        check_all(tag);
    endtask

    task automatic step(input string tag, input logic [7:0] ow, input logic dw,
                        input logic [1:0] sel, input logic nr, input logic cl);
        int  nbits;
        bit  err;
        bit  any;
        bit  final_tile;
        op_we = ow; data_we = dw; jklm_select = sel; next_row = nr; column = cl;

        nbits = $countones(ow);
        err   = (nbits > 1) || (nbits != 0 && dw);
        any   = (ow != 0) || dw || nr || cl;
        mrd_en = !err && (nbits == 1);
        mwr_en = !err && dw;
        if (mrd_en) begin
            for (int b = 0; b < 8; b++) if (ow[b]) mrd_addr = operand_addr(7 - b);
        end
        if (mwr_en) mwr_addr = elem(Z_BASE, 2 * mr + int'(sel) / 2, 2 * mc + int'(sel) % 2);
        if (err) mproto = 1;

        if (cl) begin
            final_tile = (mr == T - 1) && (mc == T - 1);
            mk = 0;
            if (mc == T - 1) begin
                mc = 0;
                mr = (mr == T - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
            if (final_tile) mdone = 1;
            else mdone = 0;
        end else begin
            if (nr) mk = (mk + 1) % T;
            if (any) mdone = 0;
        end

        @(posedge Clk); #1;
        op_we = '0; data_we = 1'b0; jklm_select = '0; next_row = 1'b0; column = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int kind;
        logic [7:0] ow;
        logic dw, nr, cl;

        // Reset, then a lone weA read of X[0][0]
        do_reset("reset");
        step("weA", 8'b1000_0000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("weA.rd_en_lit", 32'(rd_en), 32'd1);
        check("weA.rd_addr_lit", 32'(rd_addr), 32'd0);
        step("idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        check("idle.rd_en_lit", 32'(rd_en), 32'd0);
        check("idle.mat_done_lit", 32'(mat_done), 32'd0);

        // k advance, then X[1][3] and Y[2][0]
        step("next_row", 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
        step("weD", 8'b0001_0000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("weD.rd_addr_lit", 32'(rd_addr), 32'd7);
        step("weE", 8'b0000_1000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("weE.rd_addr_lit", 32'(rd_addr), 32'd24);

        // Next tile, store K -> Z[0][3]
        step("column", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        step("storeK", 8'h00, 1'b1, 2'd1, 1'b0, 1'b0);
        check("storeK.wr_en_lit", 32'(wr_en), 32'd1);
        check("storeK.wr_addr_lit", 32'(wr_addr), 32'd35);

        // Store with column in the same cycle uses the pre-advance tile; column beats next_row
        step("storeM_col", 8'h00, 1'b1, 2'd3, 1'b1, 1'b1);
        step("weB_after", 8'b0100_0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Full pass of four tiles ends in DONE; next strobe restarts from tile 0
        do_reset("reset2");
        for (int i = 0; i < 4; i++) step("col_pass", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        check("pass.mat_done_lit", 32'(mat_done), 32'd1);
        step("idle_done", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        check("idle_done.mat_done_lit", 32'(mat_done), 32'd1);
        step("weA_restart", 8'b1000_0000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("restart.rd_addr_lit", 32'(rd_addr), 32'd0);
        check("restart.mat_done_lit", 32'(mat_done), 32'd0);

        // Protocol errors are sticky through valid traffic
        step("two_ops", 8'b1100_0000, 1'b0, 2'd0, 1'b0, 1'b0);
        check("two_ops.rd_en_lit", 32'(rd_en), 32'd0);
        check("two_ops.proto_err_lit", 32'(proto_err), 32'd1);
        step("valid_after_err", 8'b0000_0001, 1'b0, 2'd0, 1'b0, 1'b0);
        step("op_and_store", 8'b0010_0000, 1'b1, 2'd2, 1'b1, 1'b0);
        check("op_and_store.wr_en_lit", 32'(wr_en), 32'd0);
        check("sticky.proto_err_lit", 32'(proto_err), 32'd1);

        // Reset mid-pass at (r=1,c=1) then weH reads Y[1][1]
        do_reset("reset3");
        for (int i = 0; i < 3; i++) step("col_mid", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
        step("weH_mid", 8'b0000_0001, 1'b0, 2'd0, 1'b0, 1'b0);
        do_reset("reset_mid");
        check("reset_mid.rd_addr_lit", 32'(rd_addr), 32'd0);
        check("reset_mid.proto_err_lit", 32'(proto_err), 32'd0);
        step("weH", 8'b0000_0001, 1'b0, 2'd0, 1'b0, 1'b0);
        check("weH.rd_addr_lit", 32'(rd_addr), 32'd21);

        // Random traffic against the model
        do_reset("reset_rand");
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 79) do_reset("reset_rand_n");
            kind = int'($urandom_range(0, 19));
            ow = '0; dw = 1'b0;
            if (kind < 10) begin
                ow = 8'(1) << $urandom_range(0, 7);
            end else if (kind < 15) begin
                dw = 1'b1;
            end else if (kind == 18) begin
                ow = 8'($urandom_range(0, 255));
            end else if (kind == 19) begin
                ow = 8'(1) << $urandom_range(0, 7);
                dw = 1'b1;
            end
            nr = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 4) == 0);
            step("rand", ow, dw, 2'($urandom_range(0, 3)), nr, cl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
